stft_frame_sequencer: RTL and testbench

//  Turns the continuous sample stream (in_valid/d_in, post pipeline delay) into overlapping STFT frames.

---
 rtl/stft_pkg.sv | 18 +
 rtl/stft_frame_sequencer_skid.sv | 58 +++++
 rtl/stft_frame_sequencer.sv | 131 +++++++++++++
 tb/tb_stft_frame_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/stft_pkg.sv
// Shared definitions for the STFT frame sequencer: FSM encoding, default geometry, beat record width.
package stft_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int FRAME_LOG2 = 8;
  localparam int HOP        = 128;
  localparam int MEM_LOG2   = 9;
  localparam int FRAME_LEN  = 2**FRAME_LOG2;
  localparam int DEPTH      = 2**MEM_LOG2;

  typedef enum logic [1:0] {FILL = 2'd0, READ = 2'd1, DRAIN = 2'd2} seq_state_e;

  // Beat record: {data, idx, sop, eop}
  function automatic int beat_w(input int ws, input int fl);
    return ws + fl + 2;
  endfunction

  localparam int BEAT_W = beat_w(WORD_SIZE, FRAME_LOG2);
endpackage

// File: rtl/stft_frame_sequencer_skid.sv
// frame_skid_fifo: 2-entry output FIFO fed by a 1-cycle-latency RAM read; tracks the read in flight
// so the issuer never launches a read that would not fit.
module frame_skid_fifo
  import stft_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full_m1,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid
);
  logic         inflight_q;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e1_q, e0_d, e1_d;
  logic         pop_eff;
  logic [2:0]   occ;

  assign pop_eff = pop && (cnt_q != 2'd0);
  // Occupancy after this cycle's pop, counting the read whose data lands next edge.
  assign occ     = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop_eff};
  assign full_m1 = occ >= 3'd2;
  assign dout    = e0_q;
  assign valid   = cnt_q != 2'd0;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop_eff) begin
      e0_d  = e1_q;
      cnt_d = cnt_d - 2'd1;
    end
    if (inflight_q) begin
      if (cnt_d == 2'd0) e0_d = din;
      else               e1_d = din;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      inflight_q <= push;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end
endmodule

// File: rtl/stft_frame_sequencer.sv
// Circular sample RAM replayed as overlapping FRAME_LEN frames, HOP apart, over valid/ready.
// Optional STFT_OVERRUN_CNT_EN adds a saturating dropped-sample counter output.
module stft_frame_sequencer
  import stft_pkg::*;
#(
  parameter int word_size  = WORD_SIZE,
  parameter int frame_log2 = FRAME_LOG2,
  parameter int hop        = HOP,
  parameter int mem_log2   = MEM_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [word_size-1:0]  d_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [word_size-1:0]  out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [frame_log2-1:0] out_idx,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
`ifdef STFT_OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt
`endif
);
  localparam int FLEN = 2**frame_log2;
  localparam int DPTH = 2**mem_log2;
  localparam int AW   = mem_log2;
  localparam int CW   = mem_log2 + 1;
  localparam int BW   = beat_w(word_size, frame_log2);
  localparam logic [frame_log2-1:0] LAST = frame_log2'(FLEN - 1);

  logic [word_size-1:0]  mem [DPTH];
  logic [AW-1:0]         wptr_q, base_q, base_d, rptr_q, rptr_d;
  logic [CW-1:0]         avail_q, avail_d;
  logic [frame_log2-1:0] rd_cnt_q, rd_cnt_d;
  seq_state_e            state_q, state_d;
  logic                  we, drop, rel, issue, full_m1;
  logic [word_size-1:0]  rdata_q;
  logic [frame_log2+1:0] meta_q;
  logic [BW-1:0]         head;

  assign we      = in_valid && (avail_q < CW'(DPTH));
  assign drop    = in_valid && !we;
  assign rel     = out_valid && out_ready && out_eop;
  assign issue   = (state_q == READ) && !full_m1;
  assign avail_d = avail_q + CW'(we) - (rel ? CW'(hop) : '0);
  assign base_d  = rel ? base_q + AW'(hop) : base_q;
  assign busy    = state_q != FILL;

  always_comb begin
    state_d  = state_q;
    rptr_d   = rptr_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      FILL: if (avail_q >= CW'(FLEN)) begin
        state_d  = READ;
        rptr_d   = base_q;
        rd_cnt_d = '0;
      end
      READ: if (issue) begin
        rptr_d   = rptr_q + AW'(1);
        rd_cnt_d = rd_cnt_q + frame_log2'(1);
        if (rd_cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: if (rel) begin
        // Post-release occupancy decides whether the next frame can start immediately.
        if (avail_d >= CW'(FLEN)) begin
          state_d  = READ;
          rptr_d   = base_d;
          rd_cnt_d = '0;
        end else begin
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      wptr_q   <= '0;
      base_q   <= '0;
      avail_q  <= '0;
      rptr_q   <= '0;
      rd_cnt_q <= '0;
      meta_q   <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      avail_q  <= avail_d;
      rptr_q   <= rptr_d;
      rd_cnt_q <= rd_cnt_d;
      if (we)    wptr_q <= wptr_q + AW'(1);
      if (issue) meta_q <= {rd_cnt_q, rd_cnt_q == '0, rd_cnt_q == LAST};
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we)    mem[wptr_q] <= d_in;
    if (issue) rdata_q     <= mem[rptr_q];
  end

  frame_skid_fifo #(.W(BW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (issue),
    .din     ({rdata_q, meta_q}),
    .full_m1 (full_m1),
    .pop     (out_ready),
    .dout    (head),
    .valid   (out_valid)
  );

  assign {out_data, out_idx, out_sop, out_eop} = head;

`ifdef STFT_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                overrun_cnt <= '0;
    else if (overrun_clr)                     overrun_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_stft_frame_sequencer.sv
// Scoreboard bench: frames are derived from the list of accepted samples (frame f = samples f*HOP ..).
module tb_stft_frame_sequencer;
  import stft_pkg::*;
  localparam int FL  = FRAME_LEN;
  localparam int DP  = DEPTH;
  localparam int HP  = HOP;
  localparam int FLG = FRAME_LOG2;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, overrun_clr = 1'b0;
  logic [15:0] d_in = '0;
  logic        out_valid, out_sop, out_eop, overrun, busy;
  logic [15:0] out_data;
  logic [7:0]  out_idx;
`ifdef STFT_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  always #5 clk = ~clk;

  stft_frame_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d_in(d_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_idx(out_idx), .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
`ifdef STFT_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  int pass_cnt = 0, tot_cnt = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  logic [25:0] exp_q[$];
  logic [15:0] acc[$];
  int n_acc = 0, n_frm = 0, n_rel = 0, cyc = 0, sop_cyc = 0;
  bit full_rate = 0;

  // Monitor: compares every accepted beat with the head of the expected queue.
  logic        prev_stall = 0;
  logic [25:0] prev_beat, beat, e;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      n_rel = 0;
      prev_stall = 0;
    end else begin
      beat = {out_data, out_idx, out_sop, out_eop};
      if (prev_stall) chk("stall_hold", {out_valid, beat}, {1'b1, prev_beat});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL extra_beat: got %0h expected none", beat);
        end else begin
          e = exp_q.pop_front();
          chk("beat", beat, e);
        end
        if (out_sop) sop_cyc = cyc;
        if (out_eop) begin
          n_rel++;
          if (full_rate) chk("frame_span", cyc - sop_cyc, FL - 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = beat;
    end
  end

  // One cycle of stimulus; the model accepts a sample only while fewer than DEPTH are held.
  task automatic step(input bit v, input logic [15:0] d, input bit r, input bit c);
    @(posedge clk); #1;
    in_valid = v; d_in = d; out_ready = r; overrun_clr = c;
    if (!reset && v && (n_acc - n_rel * HP) < DP) begin
      acc.push_back(d);
      n_acc++;
      while (n_frm * HP + FL <= n_acc) begin
        for (int i = 0; i < FL; i++)
          exp_q.push_back({acc[n_frm * HP + i], FLG'(i), i == 0, i == FL - 1});
        n_frm++;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; in_valid = 0; out_ready = 0; overrun_clr = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    exp_q.delete(); acc.delete(); n_acc = 0; n_frm = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && (exp_q.size() != 0 || out_valid); k++) step(0, 0, 1, 0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("init_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_overrun", overrun, 0);
    chk("init_beat", {out_data, out_idx, out_sop, out_eop}, 0);
    @(posedge clk); #1 reset = 0;

    // Ramp, full-rate consumer; writes coincide with eop acceptances along the way.
    full_rate = 1;
    for (int k = 0; k < 1000; k++) step(1, 16'(k), 1, 0);
    drain();
    full_rate = 0;

    // Random input and random backpressure.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, 16'(1000 + k), 1'($urandom_range(0, 1)), 0);
    drain();

    // Consumer stalled: RAM fills to DEPTH, then samples drop.
    do_reset();
    for (int k = 0; k < 700; k++) begin
      step(1, 16'(k), 0, 0);
      if (k == 512) chk("ovr_before_drop", overrun, 0);
      if (k == 513) chk("ovr_after_drop", overrun, 1);
    end
    step(0, 0, 0, 0);
    chk("ovr_sticky", overrun, 1);
`ifdef STFT_OVERRUN_CNT_EN
    chk("ovr_cnt", overrun_cnt, 188);
`endif
    drain();
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("ovr_cleared", overrun, 0);
`ifdef STFT_OVERRUN_CNT_EN
    chk("ovr_cnt_cleared", overrun_cnt, 0);
`endif

    // Reset in the middle of a frame; next frame must start at the first post-reset sample.
    begin
      int k;
      for (k = 0; k < 1000 && !(busy && out_valid && out_idx > 8'd10); k++)
        step(1, 16'(2000 + k), 1, 0);
      chk("midframe_reached", k < 1000, 1);
    end
    do_reset();
    for (int k = 0; k < 700; k++) step(1, 16'(3000 + k), 1, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
